// File: rtl/dmem_wait_resp_if.sv
// MEM-stage data-memory bus between the CPU (master) and the wait-state responder (slave).
// Request signals come from the CPU and response signals come back from the memory.
interface dmem_wait_resp_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        done;
    logic        err;

    modport master (
        output mem_read, mem_write, addr, write_data,
        input  read_data, stall, done, err
    );

    modport slave (
        input  mem_read, mem_write, addr, write_data,
        output read_data, stall, done, err
    );
endinterface

// File: rtl/dmem_wait_resp.sv
// Data memory for the MEM stage. It inserts WAIT_CYCLES wait states per access and
// stalls the pipeline until a one-cycle done/err response is given.
module dmem_wait_resp #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_wait_resp_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             is_write_q, is_write_d;
    logic [31:0]      read_data_q;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             req;
    logic             bad;
    logic             rd_load;
    logic [IDX_W-1:0] rd_idx;
    logic             mem_we;

    // NOTE: the storage array has no reset; its contents stay undefined until written.
    logic [31:0] mem [DEPTH_WORDS];

    assign req    = bus.mem_read | bus.mem_write;
    assign bad    = (bus.addr[1:0] != 2'b00) ||
                    ({2'b00, bus.addr[31:2]} >= 32'(DEPTH_WORDS));
    // err_q is high in RESP only for rejected accesses, so it also blocks the commit.
    assign mem_we = (state_q == S_RESP) && is_write_q && !err_q && !reset;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latches are inferred.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rd_load    = 1'b0;
        rd_idx     = idx_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d      = bus.addr[IDX_W+1:2];
                    wdata_d    = bus.write_data;
                    is_write_d = bus.mem_write;
                    rd_idx     = bus.addr[IDX_W+1:2];
                    if (bad) begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        rd_load = !bus.mem_write;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    done_d  = 1'b1;
                    rd_load = !is_write_q;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 4'd0;
            idx_q       <= '0;
            wdata_q     <= 32'h0;
            is_write_q  <= 1'b0;
            read_data_q <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            done_q     <= done_d;
            err_q      <= err_d;
            if (rd_load) read_data_q <= mem[rd_idx];
        end
    end

    // Writes commit on the edge leaving RESP, so the next accepted read sees them.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= wdata_q;
    end

    assign bus.stall     = !reset && (((state_q == S_IDLE) && req) || (state_q == S_WAIT));
    assign bus.read_data = read_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: doc/dmem_wait_resp.md
# dmem_wait_resp

Data-memory responder for the pipelined CPU's MEM stage. It accepts the CPU's read/write requests (`mem_read`, `mem_write`, `addr`, `write_data`), inserts a programmable number of wait states, and drives a `stall` signal that freezes the pipeline until the access completes. It replaces the zero-latency data memory, so the core can be exercised against slow memory.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words. Must be a power of two, at most 2^30.
- `WAIT_CYCLES`, 2: wait states inserted per access. Legal range 0..15.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `mem_read`  in  1: read request from the MEM stage.
- `mem_write`  in  1: write request from the MEM stage. Has priority over `mem_read` if both are high.
- `addr`  in  32: byte address.
- `write_data`  in  32: store data.
- `read_data`  out  32: registered load data. Held until the next successful read completes.
- `stall`  out  1: combinational. While high, the CPU holds the PC and all pipeline registers.
- `done`  out  1: registered. High for exactly one cycle when an access completes.
- `err`  out  1: registered. High together with `done` when the access was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP. A 4-bit counter `wait_cnt` runs in WAIT.
- IDLE, no request (`req = mem_read | mem_write` is 0): stay in IDLE.
- IDLE, `req` = 1, accept edge:
  - Capture `addr`, `write_data` and the operation (write if `mem_write`, else read) into holding registers.
  - Evaluate the error condition `bad = (addr[1:0] != 0) | (addr[31:2] >= DEPTH_WORDS)`.
  - If `bad`: go to RESP with the error flag set, skipping WAIT.
  - Else if `WAIT_CYCLES == 0`: go to RESP.
  - Else: load `wait_cnt = WAIT_CYCLES-1` and go to WAIT.
- WAIT: if `wait_cnt == 0`, go to RESP; else decrement `wait_cnt`. Input changes are ignored; only the captured values are used.
- Entering RESP on a good read: `read_data <= mem[captured addr[31:2]]`.
- Good write: memory updated on the edge leaving RESP, using the captured word index and data.
- Error access: no memory read or write, and `read_data` is unchanged.
- RESP: `done` = 1, and `err` = captured error flag. Always go to IDLE on the next edge. Requests present during RESP are ignored, because the CPU still shows the just-finished request.
- `stall = (state==IDLE & req) | (state==WAIT)`. `stall` is 0 in RESP, which lets the pipeline advance at the end of the RESP cycle.
- Memory array has no reset. Contents are undefined until written.

## Timing
- Reset values: state IDLE, `wait_cnt` 0, `read_data` 32'h0, `done` 0, `err` 0.
- `stall` is 0 while `reset` is high.
- Good access issued in cycle 0:
  - `stall` high in cycles 0..WAIT_CYCLES (WAIT_CYCLES+1 cycles).
  - `done`/`read_data` valid in cycle WAIT_CYCLES+1.
  - A new request is accepted no earlier than cycle WAIT_CYCLES+2.
- Error access issued in cycle 0: `stall` high in cycle 0 only; `done` and `err` high in cycle 1. Holds for any `WAIT_CYCLES`.
- Back-to-back requests: throughput is one access per WAIT_CYCLES+2 cycles.
- Reset asserted in WAIT or RESP: the access is aborted, and a pending write is not committed. In RESP with reset high, `done` goes 0 on that edge and the memory is not written.
- A read to the same word immediately after a write returns the new data, since the write commits before the next IDLE accept.

## Test plan
- Reset, then idle with `mem_read` = `mem_write` = 0 for 5 cycles -> `stall` = 0, `done` = 0, `err` = 0, `read_data` = 0.
- `WAIT_CYCLES` = 2: write 32'hDEADBEEF to `addr` 32'h10 -> `stall` high 3 cycles, `done` pulse in cycle 3, `err` = 0. Then read 32'h10 -> `read_data` = 32'hDEADBEEF with `done`, 3-cycle stall.
- Misaligned read at 32'h12 -> `stall` 1 cycle, `done` and `err` in cycle 1, `read_data` unchanged. Out-of-range write at 32'h400 (`DEPTH_WORDS` = 256) -> `err` = 1, and a later read of 32'h0 still returns the prior value.
- `mem_read` and `mem_write` both high at 32'h20 with data 32'h5 -> treated as a write. A following read of 32'h20 returns 32'h5.
- `addr`/`write_data` changed to 32'h30/32'h1 during WAIT of a write to 32'h20 with 32'h7 -> mem[32'h20] = 32'h7, and mem[32'h30] is untouched.
- Reset pulsed in WAIT of a write of 32'hAA to 32'h40, which previously held 32'h11 -> FSM in IDLE, and a later read of 32'h40 returns 32'h11. Separately, `WAIT_CYCLES` = 0 -> a good access stalls 1 cycle with `done` in cycle 1.
